// File: rtl/sincos_nco_multi.sv
// Multi-channel NCO: per-channel phase accumulators time-share one registered
// quarter-wave sine ROM, emitting one sin/cos pair per channel for every tick.
module sincos_nco_multi #(
  parameter int ROM_DEPTH = 64,
  parameter int ROM_WIDTH = 8,
  parameter int CHANNELS  = 4,
  parameter int PHASEW    = 16,
  parameter int ADDRW     = $clog2(4 * ROM_DEPTH),
  parameter int CHW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  input  logic                          cfg_clr,
  input  logic [CHW-1:0]                cfg_ch,
  input  logic [PHASEW-1:0]             cfg_step,
  input  logic                          tick,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHW-1:0]                out_ch,
  output logic signed [2*ROM_WIDTH-1:0] out_sin,
  output logic signed [2*ROM_WIDTH-1:0] out_cos,
  output logic                          busy,
  output logic                          overrun
);

  localparam int IW = ADDRW - 2;
  localparam int OW = 2 * ROM_WIDTH;

  // Built-in quarter-wave image: entry k = floor(sin(k*90/64 deg) * 256), entry 63 first.
  localparam logic [63:0][7:0] SINE_TAB = {
    8'd255, 8'd255, 8'd255, 8'd254, 8'd254, 8'd253, 8'd252, 8'd251,
    8'd249, 8'd248, 8'd246, 8'd244, 8'd243, 8'd241, 8'd238, 8'd236,
    8'd234, 8'd231, 8'd228, 8'd225, 8'd222, 8'd219, 8'd216, 8'd212,
    8'd209, 8'd205, 8'd201, 8'd197, 8'd193, 8'd189, 8'd185, 8'd181,
    8'd176, 8'd171, 8'd167, 8'd162, 8'd157, 8'd152, 8'd147, 8'd142,
    8'd136, 8'd131, 8'd126, 8'd120, 8'd115, 8'd109, 8'd103, 8'd97,
    8'd92,  8'd86,  8'd80,  8'd74,  8'd68,  8'd62,  8'd56,  8'd49,
    8'd43,  8'd37,  8'd31,  8'd25,  8'd18,  8'd12,  8'd6,   8'd0
  };

  typedef enum logic [2:0] {IDLE, SIN, COS, FIN, OUT} state_t;

  state_t                 state_q, state_d;
  logic [CHW-1:0]         ch_q;
  logic [PHASEW-1:0]      phase_q  [CHANNELS];
  logic [PHASEW-1:0]      step_q   [CHANNELS];
  logic [ADDRW-1:0]       shadow_q [CHANNELS];
  logic [ADDRW-1:0]       idx, addr;
  logic [IW-1:0]          tab;
  logic                   start, hs, last;
  logic [ROM_WIDTH-1:0]   rom_p0;
  logic                   neg_p0, one_p0;

  // Apply quadrant sign; the exact +/-1.0 case bypasses the ROM.
  function automatic logic signed [OW-1:0] shape(input logic [ROM_WIDTH-1:0] q,
                                                 input logic neg, input logic one);
    logic signed [OW-1:0] mag;
    mag = one ? $signed(OW'(1) << ROM_WIDTH) : $signed({{ROM_WIDTH{1'b0}}, q});
    return neg ? -mag : mag;
  endfunction

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    hs      = 1'b0;
    last    = (ch_q == CHW'(CHANNELS - 1));
    case (state_q)
      IDLE: if (tick) begin
        start   = 1'b1;
        state_d = SIN;
      end
      SIN:  state_d = COS;
      COS:  state_d = FIN;
      FIN:  state_d = OUT;
      OUT:  if (out_valid && out_ready) begin
        hs      = 1'b1;
        state_d = last ? IDLE : SIN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx  = shadow_q[ch_q];
    addr = (state_q == COS) ? idx + ADDRW'(ROM_DEPTH) : idx;
    tab  = addr[IW] ? IW'(ROM_DEPTH - int'(addr[IW-1:0])) : addr[IW-1:0];
  end

  // p0: ROM read plus the fold flags that travel with it
  always_ff @(posedge clk) begin
    rom_p0 <= ROM_WIDTH'(SINE_TAB[tab]);
    neg_p0 <= addr[ADDRW-1];
    one_p0 <= addr[IW] && (addr[IW-1:0] == '0);
    if (start) begin
      for (int c = 0; c < CHANNELS; c++) shadow_q[c] <= phase_q[c][PHASEW-1 -: ADDRW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_sin   <= '0;
      out_cos   <= '0;
      overrun   <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        phase_q[c] <= '0;
        step_q[c]  <= '0;
      end
    end else begin
      state_q <= state_d;
      if (start)            ch_q <= '0;
      else if (hs && !last) ch_q <= ch_q + 1'b1;
      if (state_q == COS) out_sin <= shape(rom_p0, neg_p0, one_p0);
      if (state_q == FIN) begin
        out_cos   <= shape(rom_p0, neg_p0, one_p0);
        out_ch    <= ch_q;
        out_valid <= 1'b1;
      end else if (hs) begin
        out_valid <= 1'b0;
      end
      if (tick && busy) overrun <= 1'b1;
      else if (cfg_clr) overrun <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        if (cfg_clr && cfg_ch == CHW'(c)) phase_q[c] <= '0;
        else if (tick)                    phase_q[c] <= phase_q[c] + step_q[c];
        if (cfg_we && cfg_ch == CHW'(c))  step_q[c]  <= cfg_step;
      end
    end
  end

endmodule

// File: tb/tb_sincos_nco_multi.sv
// Randomized and directed bench for sincos_nco_multi against a real-valued
// sin/cos reference with a transaction-level sweep model.
module tb_sincos_nco_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0, cfg_clr = 1'b0, tick = 1'b0, out_ready = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [15:0] cfg_step = '0;
  logic        out_valid, busy, overrun;
  logic [1:0]  out_ch;
  logic signed [15:0] out_sin, out_cos;

  sincos_nco_multi dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_clr(cfg_clr), .cfg_ch(cfg_ch),
    .cfg_step(cfg_step), .tick(tick), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_sin(out_sin), .out_cos(out_cos), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {int ch; logic [15:0] s; logic [15:0] c;} smp_t;

  smp_t        m_q[$];
  logic [15:0] m_phase [4];
  logic [15:0] m_step  [4];
  bit          m_busy, m_over, m_valid;
  int          m_wait;
  logic [15:0] last_s [4];
  logic [15:0] last_c [4];
  int          checks = 0, errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Q8.8 value of floor(256*|f(angle)|) with the sign of f, angle = idx * 360/256 deg.
  function automatic logic [15:0] ref_val(input int idx, input bit use_cos);
    real a, v, m;
    int  mag;
    a   = idx * 3.141592653589793 / 128.0;
    v   = use_cos ? $cos(a) : $sin(a);
    m   = (v < 0.0) ? -v : v;
    mag = $rtoi(m * 256.0 + 1.0e-9);
    return (v < 0.0) ? 16'(-mag) : 16'(mag);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_phase[k] = '0;
      m_step[k]  = '0;
    end
    m_q.delete();
    m_busy = 0; m_over = 0; m_valid = 0; m_wait = 0;
  endtask

  task automatic poison();
    for (int k = 0; k < 4; k++) begin
      last_s[k] = 16'hDEAD;
      last_c[k] = 16'hDEAD;
    end
  endtask

  // One clock: advance the model for the inputs now applied, clock, then compare.
  task automatic clk_step();
    bit hs;
    hs = m_valid && out_ready;
    if (hs) begin
      last_s[out_ch] = out_sin;
      last_c[out_ch] = out_cos;
    end
    if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) m_valid = 1;
    end
    if (cfg_clr) m_over = 0;
    if (tick && m_busy) m_over = 1;
    if (tick && !m_busy) begin
      for (int k = 0; k < 4; k++) begin
        smp_t e;
        int   ix;
        ix   = int'(m_phase[k] >> 8);
        e.ch = k;
        e.s  = ref_val(ix, 1'b0);
        e.c  = ref_val(ix, 1'b1);
        m_q.push_back(e);
      end
      m_busy = 1;
      m_wait = 3;
    end else if (hs) begin
      void'(m_q.pop_front());
      m_valid = 0;
      if (m_q.size() == 0) m_busy = 0;
      else                 m_wait = 3;
    end
    for (int k = 0; k < 4; k++) begin
      if (cfg_clr && cfg_ch == 2'(k)) m_phase[k] = '0;
      else if (tick)                  m_phase[k] = m_phase[k] + m_step[k];
    end
    if (cfg_we) m_step[cfg_ch] = cfg_step;
    @(posedge clk);
    @(negedge clk);
    tick = 0; cfg_we = 0; cfg_clr = 0;
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check_eq("busy", {31'd0, busy}, {31'd0, m_busy});
    check_eq("overrun", {31'd0, overrun}, {31'd0, m_over});
    if (m_valid) begin
      check_eq("out_ch", {30'd0, out_ch}, m_q[0].ch);
      check_eq("out_sin", {16'd0, $unsigned(out_sin)}, {16'd0, m_q[0].s});
      check_eq("out_cos", {16'd0, $unsigned(out_cos)}, {16'd0, m_q[0].c});
    end
  endtask

  task automatic do_tick();
    tick = 1;
    clk_step();
  endtask

  task automatic set_step(input int ch, input logic [15:0] v);
    cfg_we = 1; cfg_ch = 2'(ch); cfg_step = v;
    clk_step();
  endtask

  task automatic clr_ch(input int ch);
    cfg_clr = 1; cfg_ch = 2'(ch);
    clk_step();
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    out_ready = 1;
    while (m_busy && n < budget) begin
      clk_step();
      n++;
    end
    check_eq("sweep_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic sweep_ch0(input string tag, input logic [15:0] es, input logic [15:0] ec);
    poison();
    do_tick();
    run_idle(100);
    check_eq({tag, "_sin"}, {16'd0, last_s[0]}, {16'd0, es});
    check_eq({tag, "_cos"}, {16'd0, last_c[0]}, {16'd0, ec});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] q_s [4];
    logic [15:0] q_c [4];
    int lat;
    q_s = '{16'h0000, 16'h0100, 16'h0000, 16'hFF00};
    q_c = '{16'h0100, 16'h0000, 16'hFF00, 16'h0000};
    model_reset();
    poison();
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_ch", {30'd0, out_ch}, 32'd0);
    check_eq("rst_sin", {16'd0, $unsigned(out_sin)}, 32'd0);
    check_eq("rst_cos", {16'd0, $unsigned(out_cos)}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1;

    // All steps zero: every channel at phase 0, first valid three cycles after tick.
    out_ready = 1;
    do_tick();
    lat = 0;
    while (!out_valid && lat < 10) begin
      clk_step();
      lat++;
    end
    check_eq("first_latency", lat, 32'd3);
    run_idle(100);
    for (int k = 0; k < 4; k++) begin
      check_eq("zero_sin", {16'd0, last_s[k]}, 32'h0000);
      check_eq("zero_cos", {16'd0, last_c[k]}, 32'h0100);
    end

    // Quarter-turn steps on ch0 walk through the four axis points.
    set_step(0, 16'h4000);
    for (int k = 0; k < 4; k++) sweep_ch0("quad", q_s[k], q_c[k]);

    // 45 and 225 degrees.
    set_step(0, 16'h2000);
    sweep_ch0("deg0", 16'h0000, 16'h0100);
    sweep_ch0("deg45", 16'h00B5, 16'h00B5);
    set_step(0, 16'h6000);
    sweep_ch0("deg90", 16'h0100, 16'h0000);
    sweep_ch0("deg225", 16'hFF4B, 16'hFF4B);

    // Backpressure with a tick landing mid-stall.
    out_ready = 0;
    do_tick();
    for (int k = 0; k < 13; k++) begin
      if (k == 6) tick = 1;
      clk_step();
    end
    check_eq("ovr_set", {31'd0, overrun}, 32'd1);
    run_idle(100);
    check_eq("ovr_sticky", {31'd0, overrun}, 32'd1);
    clr_ch(2);
    check_eq("ovr_clr", {31'd0, overrun}, 32'd0);

    // Wrap of an all-ones step, then clear colliding with tick.
    set_step(1, 16'hFFFF);
    do_tick();
    do_tick();
    run_idle(100);
    clr_ch(3);
    poison();
    do_tick();
    run_idle(100);
    check_eq("wrap_sin", {16'd0, last_s[1]}, 32'hFFFA);
    check_eq("wrap_cos", {16'd0, last_c[1]}, 32'h00FF);
    cfg_clr = 1; cfg_ch = 2'd1; tick = 1;
    clk_step();
    run_idle(100);
    poison();
    do_tick();
    run_idle(100);
    check_eq("clrtick_sin", {16'd0, last_s[1]}, 32'h0000);
    check_eq("clrtick_cos", {16'd0, last_c[1]}, 32'h0100);

    // Reset while the first channel is in its cos cycle.
    do_tick();
    clk_step();
    rst_n = 0;
    #1;
    check_eq("abort_valid", {31'd0, out_valid}, 32'd0);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    poison();
    do_tick();
    run_idle(100);
    check_eq("fresh_sin", {16'd0, last_s[0]}, 32'h0000);
    check_eq("fresh_cos", {16'd0, last_c[0]}, 32'h0100);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      cfg_we   = ($urandom % 16) == 0;
      cfg_ch   = 2'($urandom % 4);
      cfg_step = ($urandom % 2) ? {2'($urandom % 4), 14'd0} : 16'($urandom);
      cfg_clr  = ($urandom % 32) == 0;
      tick     = cfg_clr ? 1'b0 : (($urandom % 8) == 0);
      out_ready = 1'($urandom % 2);
      clk_step();
    end
    run_idle(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
